// File: rtl/scene_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scene_pkg
// Description : Shared definitions for the scene command sequencer: command
//               word field positions, opcode encoding, sequencer states and
//               the layout of one sphere table entry.
// Revision    : 1.0  initial release
// ============================================================================
package scene_pkg;

  // Default signed fixed-point width of x/y/z/radius.
  localparam int c_coord_w   = 16;
  localparam int c_color_w   = 12;

  // 64-bit command word: [63:60] opcode, [59:56] index, [55:0] payload.
  localparam int c_op_msb    = 63;
  localparam int c_op_lsb    = 60;
  localparam int c_idx_msb   = 59;
  localparam int c_idx_lsb   = 56;
  localparam int c_payload_w = 56;

  // ATTR payload: [27:12] radius, [11:0] color.
  localparam int c_attr_rad_lsb = 12;
  localparam int c_attr_col_lsb = 0;

  typedef enum logic [3:0] {
    OP_NOP     = 4'h0,
    OP_POS     = 4'h1,
    OP_ATTR    = 4'h2,
    OP_DISABLE = 4'h3,
    OP_LIGHT   = 4'h4,
    OP_COMMIT  = 4'h5
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COPY    = 2'd2
  } seq_state_e;

  // One table entry at the default coordinate width. The table stores the
  // same fields packed MSB-first in this order: pos, radius, color, valid.
  typedef struct packed {
    logic [3*c_coord_w-1:0] pos;
    logic [c_coord_w-1:0]   radius;
    logic [c_color_w-1:0]   color;
    logic                   valid;
  } sphere_t;

endpackage
`default_nettype wire

// File: rtl/scene_bank_ram.sv
`default_nettype none
// ============================================================================
// Module      : scene_bank_ram
// Description : Two-bank register table. Bank i_active feeds the read port;
//               the other bank (shadow) takes bit-masked writes and entry
//               copies from the active bank. Copy has priority over write.
// Ports       : clk, rst          clock, asynchronous active-high reset
//               i_active          active bank select
//               i_wr_en/idx/data/mask  masked write into the shadow bank
//               i_rd_idx/o_rd_data     combinational read of the active bank
//               i_cp_en/i_cp_idx       copy active[idx] -> shadow[idx]
// Revision    : 1.0  initial release
// ============================================================================
module scene_bank_ram
  import scene_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 77
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_active,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_idx,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic [DATA_W-1:0]        i_wr_mask,
  input  logic [$clog2(DEPTH)-1:0] i_rd_idx,
  output logic [DATA_W-1:0]        o_rd_data,
  input  logic                     i_cp_en,
  input  logic [$clog2(DEPTH)-1:0] i_cp_idx
);

  logic [DATA_W-1:0] r_mem [2][DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int e = 0; e < DEPTH; e++) begin
          r_mem[b][e] <= '0;
        end
      end
    end else if (i_cp_en) begin
      r_mem[~i_active][i_cp_idx] <= r_mem[i_active][i_cp_idx];
    end else if (i_wr_en) begin
      // Only the masked fields change; the rest of the entry is kept.
      r_mem[~i_active][i_wr_idx] <= (r_mem[~i_active][i_wr_idx] & ~i_wr_mask)
                                  | (i_wr_data & i_wr_mask);
    end
  end

  assign o_rd_data = r_mem[i_active][i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/scene_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : scene_cmd_sequencer
// Description : Decodes 64-bit SPI command words into a double-buffered scene
//               table (spheres + light). Banks swap only on a renderer
//               frame_start after COMMIT; the new active bank is then copied
//               into the shadow bank and recv_interrupt tells the MCU it may
//               stream the next scene.
// Ports       : CLK100MHZ, ck_rst       clock, asynchronous active-high reset
//               recv_dv, recv_64bit     command word strobe and data
//               frame_start             renderer frame boundary pulse
//               rd_idx -> rd_pos/rd_radius/rd_color/rd_valid  active sphere
//               light_dir               active light direction
//               recv_interrupt          high = ready for next scene
//               cmd_error, overflow     sticky error flags
// Revision    : 1.0  initial release
// ============================================================================
module scene_cmd_sequencer
  import scene_pkg::*;
#(
  parameter int NUM_SPHERES = 8,
  parameter int COORD_W     = c_coord_w
) (
  input  logic                           CLK100MHZ,
  input  logic                           ck_rst,
  input  logic                           recv_dv,
  input  logic [63:0]                    recv_64bit,
  input  logic                           frame_start,
  input  logic [$clog2(NUM_SPHERES)-1:0] rd_idx,
  output logic [3*COORD_W-1:0]           rd_pos,
  output logic [COORD_W-1:0]             rd_radius,
  output logic [c_color_w-1:0]           rd_color,
  output logic                           rd_valid,
  output logic [3*COORD_W-1:0]           light_dir,
  output logic                           recv_interrupt,
  output logic                           cmd_error,
  output logic                           overflow
);

  localparam int c_idx_w   = $clog2(NUM_SPHERES);
  localparam int c_cnt_w   = c_idx_w + 1;
  localparam int c_pos_w   = 3 * COORD_W;
  localparam int c_ent_w   = c_pos_w + COORD_W + c_color_w + 1;
  localparam int c_pos_lsb = COORD_W + c_color_w + 1;

  localparam logic [c_ent_w-1:0] c_mask_pos  = {{c_pos_w{1'b1}}, {c_pos_lsb{1'b0}}};
  localparam logic [c_ent_w-1:0] c_mask_attr = {{c_pos_w{1'b0}}, {c_pos_lsb{1'b1}}};
  localparam logic [c_ent_w-1:0] c_mask_vld  = {{(c_ent_w-1){1'b0}}, 1'b1};
  // Copy step that moves the light instead of a sphere entry.
  localparam logic [c_cnt_w-1:0] c_cp_last   = c_cnt_w'(NUM_SPHERES);

  seq_state_e r_state, w_state_nxt;
  logic       r_active;
  logic       r_hold_full;
  logic [63:0] r_hold_word;
  logic [c_cnt_w-1:0] r_cp_cnt;
  logic       r_irq, r_err, r_ovf;
  logic [c_pos_w-1:0] r_light0, r_light1;

  logic       w_idle, w_proc, w_hold_load, w_hold_full_nxt, w_drop, w_accept;
  logic [63:0] w_word;
  logic [3:0] w_op_raw, w_idx_raw;
  opcode_e    w_op;
  logic [c_payload_w-1:0] w_payload;
  logic       w_idx_ok;
  logic       w_wr_en, w_light_we, w_commit, w_err;
  logic [c_ent_w-1:0] w_wr_mask, w_wr_data, w_rd_data;
  logic       w_toggle, w_copy_done, w_cp_en, w_light_cp;
  logic [c_pos_w-1:0] w_light_src;
  logic       w_unused_payload;

  // --------------------------------------------------------------------------
  // Word intake. A waiting held word is always processed first in IDLE; any
  // strobe arriving that cycle takes its place in the holding register.
  // --------------------------------------------------------------------------
  assign w_idle          = (r_state == ST_IDLE);
  assign w_proc          = w_idle & (r_hold_full | recv_dv);
  assign w_word          = r_hold_full ? r_hold_word : recv_64bit;
  assign w_hold_load     = recv_dv & (w_idle ? r_hold_full : ~r_hold_full);
  assign w_drop          = recv_dv & ~w_idle & r_hold_full;
  assign w_accept        = recv_dv & ~w_drop;
  assign w_hold_full_nxt = w_hold_load | (r_hold_full & ~w_idle);

  assign w_op_raw  = w_word[c_op_msb:c_op_lsb];
  assign w_idx_raw = w_word[c_idx_msb:c_idx_lsb];
  assign w_payload = w_word[c_payload_w-1:0];
  assign w_op      = opcode_e'(w_op_raw);
  assign w_idx_ok  = (32'(w_idx_raw) < NUM_SPHERES);

  // Payload bits above the light/position field carry no information.
  assign w_unused_payload = ^w_payload;

  assign w_wr_data = {w_payload[c_pos_w-1:0],
                      w_payload[c_attr_rad_lsb +: COORD_W],
                      w_payload[c_attr_col_lsb +: c_color_w],
                      (w_op == OP_ATTR)};

  always_comb begin
    w_wr_en    = 1'b0;
    w_wr_mask  = '0;
    w_light_we = 1'b0;
    w_commit   = 1'b0;
    w_err      = 1'b0;
    if (w_proc) begin
      case (w_op)
        OP_NOP: ;
        OP_POS: begin
          w_wr_en   = w_idx_ok;
          w_wr_mask = c_mask_pos;
          w_err     = ~w_idx_ok;
        end
        OP_ATTR: begin
          w_wr_en   = w_idx_ok;
          w_wr_mask = c_mask_attr;
          w_err     = ~w_idx_ok;
        end
        OP_DISABLE: begin
          w_wr_en   = w_idx_ok;
          w_wr_mask = c_mask_vld;
          w_err     = ~w_idx_ok;
        end
        OP_LIGHT:  w_light_we = 1'b1;
        OP_COMMIT: w_commit   = 1'b1;
        default:   w_err      = 1'b1;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer FSM
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_toggle    = 1'b0;
    w_copy_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_commit) w_state_nxt = ST_PENDING;
      end
      ST_PENDING: begin
        if (frame_start) begin
          w_toggle    = 1'b1;
          w_state_nxt = ST_COPY;
        end
      end
      ST_COPY: begin
        if (r_cp_cnt == c_cp_last) begin
          w_copy_done = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Copy steps 0..N-1 move sphere entries, step N moves the light.
  assign w_cp_en     = (r_state == ST_COPY) & (r_cp_cnt != c_cp_last);
  assign w_light_cp  = (r_state == ST_COPY) & (r_cp_cnt == c_cp_last);
  assign w_light_src = w_light_cp ? (r_active ? r_light1 : r_light0)
                                  : w_payload[c_pos_w-1:0];

  always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
    if (ck_rst) begin
      r_state     <= ST_IDLE;
      r_active    <= 1'b0;
      r_hold_full <= 1'b0;
      r_hold_word <= '0;
      r_cp_cnt    <= '0;
      r_irq       <= 1'b1;
      r_err       <= 1'b0;
      r_ovf       <= 1'b0;
      r_light0    <= '0;
      r_light1    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold_full <= w_hold_full_nxt;
      if (w_toggle)    r_active    <= ~r_active;
      if (w_hold_load) r_hold_word <= recv_64bit;
      if (r_state == ST_COPY) r_cp_cnt <= r_cp_cnt + 1'b1;
      else                    r_cp_cnt <= '0;
      // A word received in the same cycle the copy finishes means the MCU is
      // already streaming, so the clear wins.
      if (w_copy_done) r_irq <= 1'b1;
      if (w_accept)    r_irq <= 1'b0;
      if (w_err)       r_err <= 1'b1;
      if (w_drop)      r_ovf <= 1'b1;
      if (w_light_we | w_light_cp) begin
        if (r_active) r_light0 <= w_light_src;
        else          r_light1 <= w_light_src;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sphere table
  // --------------------------------------------------------------------------
  scene_bank_ram #(
    .DEPTH  (NUM_SPHERES),
    .DATA_W (c_ent_w)
  ) u_spheres (
    .clk       (CLK100MHZ),
    .rst       (ck_rst),
    .i_active  (r_active),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (w_idx_raw[c_idx_w-1:0]),
    .i_wr_data (w_wr_data),
    .i_wr_mask (w_wr_mask),
    .i_rd_idx  (rd_idx),
    .o_rd_data (w_rd_data),
    .i_cp_en   (w_cp_en),
    .i_cp_idx  (r_cp_cnt[c_idx_w-1:0])
  );

  assign rd_pos         = w_rd_data[c_ent_w-1 -: c_pos_w];
  assign rd_radius      = w_rd_data[c_color_w+1 +: COORD_W];
  assign rd_color       = w_rd_data[1 +: c_color_w];
  assign rd_valid       = w_rd_data[0];
  assign light_dir      = r_active ? r_light1 : r_light0;
  assign recv_interrupt = r_irq;
  assign cmd_error      = r_err;
  assign overflow       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_scene_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_scene_cmd_sequencer
// Description : Self-checking bench for scene_cmd_sequencer (NUM_SPHERES=8,
//               COORD_W=16): table of command/readback vectors plus directed
//               sequences for latency, overflow, disable and mid-copy reset.
// Revision    : 1.0  initial release
// ============================================================================
module tb_scene_cmd_sequencer;

  localparam int NS = 8;
  localparam logic [63:0] C_COMMIT = 64'h5000_0000_0000_0000;

  logic        CLK100MHZ = 1'b0;
  logic        ck_rst = 1'b1;
  logic        recv_dv = 1'b0;
  logic [63:0] recv_64bit = '0;
  logic        frame_start = 1'b0;
  logic [2:0]  rd_idx = '0;
  logic [47:0] rd_pos, light_dir;
  logic [15:0] rd_radius;
  logic [11:0] rd_color;
  logic        rd_valid, recv_interrupt, cmd_error, overflow;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [63:0] word;
    logic        commit;
    logic [2:0]  idx;
    logic [47:0] pos;
    logic [15:0] rad;
    logic [11:0] col;
    logic        vld;
    logic [47:0] light;
    logic        err;
  } vec_t;

  vec_t tbl [10];

  always #5 CLK100MHZ = ~CLK100MHZ;

  scene_cmd_sequencer #(.NUM_SPHERES(NS), .COORD_W(16)) dut (
    .CLK100MHZ      (CLK100MHZ),
    .ck_rst         (ck_rst),
    .recv_dv        (recv_dv),
    .recv_64bit     (recv_64bit),
    .frame_start    (frame_start),
    .rd_idx         (rd_idx),
    .rd_pos         (rd_pos),
    .rd_radius      (rd_radius),
    .rd_color       (rd_color),
    .rd_valid       (rd_valid),
    .light_dir      (light_dir),
    .recv_interrupt (recv_interrupt),
    .cmd_error      (cmd_error),
    .overflow       (overflow)
  );

  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send(input logic [63:0] w);
    recv_dv    = 1'b1;
    recv_64bit = w;
    tick();
    recv_dv    = 1'b0;
    recv_64bit = '0;
  endtask

  // One idle cycle (lets a held COMMIT reach PENDING), a frame pulse, then
  // a bounded wait for the copy to finish.
  task automatic run_frame(input string name);
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 4*NS && !recv_interrupt; i++) tick();
    chk(name, recv_interrupt, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //            word                    cm  idx   pos                rad       col     v     light               err
    tbl[0] = '{64'h1500_1234_5678_9ABC, 1'b1, 3'd5, 48'h1234_5678_9ABC, 16'h0000, 12'h000, 1'b0, 48'h0,              1'b0};
    tbl[1] = '{64'h2500_0000_07FF_F0AB, 1'b1, 3'd5, 48'h1234_5678_9ABC, 16'h7FFF, 12'h0AB, 1'b1, 48'h0,              1'b0};
    tbl[2] = '{64'h4000_8000_4000_C000, 1'b1, 3'd2, 48'h0010_FFF0_0100, 16'h0040, 12'hF00, 1'b1, 48'h8000_4000_C000, 1'b0};
    tbl[3] = '{64'h1700_FFFF_FFFF_FFFF, 1'b0, 3'd7, 48'h0,              16'h0000, 12'h000, 1'b0, 48'h8000_4000_C000, 1'b0};
    tbl[4] = '{64'h0000_0000_0000_0000, 1'b1, 3'd7, 48'hFFFF_FFFF_FFFF, 16'h0000, 12'h000, 1'b0, 48'h8000_4000_C000, 1'b0};
    tbl[5] = '{64'h3500_0000_0000_0000, 1'b1, 3'd5, 48'h1234_5678_9ABC, 16'h7FFF, 12'h0AB, 1'b0, 48'h8000_4000_C000, 1'b0};
    tbl[6] = '{64'h2000_0000_0000_1FFF, 1'b1, 3'd0, 48'h0,              16'h0001, 12'hFFF, 1'b1, 48'h8000_4000_C000, 1'b0};
    tbl[7] = '{64'h9200_0000_0000_0001, 1'b1, 3'd2, 48'h0010_FFF0_0100, 16'h0040, 12'hF00, 1'b1, 48'h8000_4000_C000, 1'b1};
    tbl[8] = '{64'h1800_AAAA_BBBB_CCCC, 1'b1, 3'd0, 48'h0,              16'h0001, 12'hFFF, 1'b1, 48'h8000_4000_C000, 1'b1};
    tbl[9] = '{64'h1300_0001_0002_0003, 1'b1, 3'd3, 48'h0001_0002_0003, 16'h0000, 12'h000, 1'b0, 48'h8000_4000_C000, 1'b1};

    // Reset values
    repeat (3) @(posedge CLK100MHZ);
    #1;
    chk("rst_irq",   recv_interrupt, 1);
    chk("rst_err",   cmd_error, 0);
    chk("rst_ovf",   overflow, 0);
    chk("rst_pos",   rd_pos, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_light", light_dir, 0);
    ck_rst = 1'b0;
    tick();

    // First scene: exact swap and interrupt latency
    send(64'h1200_0010_FFF0_0100);
    chk("b_irq_clear", recv_interrupt, 0);
    send(64'h2200_0000_0004_0F00);
    send(C_COMMIT);
    rd_idx = 3'd2;
    #1;
    chk("b_pre_swap_valid", rd_valid, 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("b_pos",    rd_pos, 48'h0010_FFF0_0100);
    chk("b_radius", rd_radius, 16'h0040);
    chk("b_color",  rd_color, 12'hF00);
    chk("b_valid",  rd_valid, 1);
    repeat (NS) tick();
    chk("b_irq_still_low", recv_interrupt, 0);
    tick();
    chk("b_irq_high", recv_interrupt, 1);

    // Table-driven vectors
    for (int k = 0; k < 10; k++) begin
      send(tbl[k].word);
      if (tbl[k].commit) begin
        send(C_COMMIT);
        run_frame($sformatf("v%0d_irq", k));
      end else begin
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        tick();
      end
      rd_idx = tbl[k].idx;
      #1;
      chk($sformatf("v%0d_pos", k),   rd_pos,    tbl[k].pos);
      chk($sformatf("v%0d_rad", k),   rd_radius, tbl[k].rad);
      chk($sformatf("v%0d_col", k),   rd_color,  tbl[k].col);
      chk($sformatf("v%0d_vld", k),   rd_valid,  tbl[k].vld);
      chk($sformatf("v%0d_light", k), light_dir, tbl[k].light);
      chk($sformatf("v%0d_err", k),   cmd_error, tbl[k].err);
    end

    // Holding register: first word held, second dropped
    send(C_COMMIT);
    send(64'h1400_0004_0004_0004);
    chk("ovf_after_one_held", overflow, 0);
    send(64'h1600_0006_0006_0006);
    chk("ovf_set", overflow, 1);
    run_frame("ovf_irq");
    tick();
    rd_idx = 3'd4;
    #1;
    chk("held_not_active_yet", rd_pos, 0);
    send(C_COMMIT);
    run_frame("held_commit_irq");
    rd_idx = 3'd4;
    #1;
    chk("held_applied", rd_pos, 48'h0004_0004_0004);
    rd_idx = 3'd6;
    #1;
    chk("dropped_absent", rd_pos, 0);

    // Disable keeps position through the copy
    send(64'h3200_0000_0000_0000);
    send(C_COMMIT);
    run_frame("dis_irq");
    rd_idx = 3'd2;
    #1;
    chk("dis_valid",  rd_valid, 0);
    chk("dis_pos",    rd_pos, 48'h0010_FFF0_0100);
    chk("dis_radius", rd_radius, 16'h0040);

    // Reset in the middle of a copy
    send(64'h1100_0111_0222_0333);
    send(C_COMMIT);
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    tick();
    #3;
    ck_rst = 1'b1;
    #1;
    chk("mid_rst_irq",   recv_interrupt, 1);
    chk("mid_rst_err",   cmd_error, 0);
    chk("mid_rst_ovf",   overflow, 0);
    chk("mid_rst_pos",   rd_pos, 0);
    chk("mid_rst_rad",   rd_radius, 0);
    chk("mid_rst_valid", rd_valid, 0);
    chk("mid_rst_light", light_dir, 0);
    @(negedge CLK100MHZ);
    ck_rst = 1'b0;
    tick();
    send(64'h1100_0111_0222_0333);
    send(C_COMMIT);
    run_frame("post_rst_irq");
    rd_idx = 3'd1;
    #1;
    chk("post_rst_pos", rd_pos, 48'h0111_0222_0333);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/scene_cmd_sequencer.md
Name: scene_cmd_sequencer

Overview:
- Sits between the 64-bit SPI slave and the raytracing renderer, in the CLK100MHZ domain.
- Decodes received 64-bit command words and writes sphere/light parameters into a double-buffered scene table.
- Swaps banks only at a renderer frame boundary, then raises recv_interrupt (drives ck_a0) to tell the MCU it may stream the next scene.

Parameters:
NUM_SPHERES, 8, sphere slots per bank (power of two, 2..16)
COORD_W, 16, signed fixed-point width of x/y/z/radius

Ports:
CLK100MHZ  in  1  system clock
ck_rst  in  1  asynchronous active-high reset (top-level inversion of ck_rst_)
recv_dv  in  1  one-cycle strobe, recv_64bit valid
recv_64bit  in  64  command word
frame_start  in  1  one-cycle pulse from renderer at start of frame
rd_idx  in  $clog2(NUM_SPHERES)  renderer read index into active bank
rd_pos  out  3*COORD_W  {x,y,z} of active sphere rd_idx (combinational read)
rd_radius  out  COORD_W  active sphere radius
rd_color  out  12  active sphere RGB444
rd_valid  out  1  active sphere enable bit
light_dir  out  3*COORD_W  active light direction
recv_interrupt  out  1  level, high = ready for next scene
cmd_error  out  1  sticky: illegal opcode or index out of range
overflow  out  1  sticky: word lost while holding register full

Behaviour:
- Word format: [63:60] opcode, [59:56] index, [55:0] payload.
- Opcodes:
  - 0x0 NOP.
  - 0x1 POS: payload[47:0] = {x,y,z}.
  - 0x2 ATTR: [27:12] radius, [11:0] color; sets valid=1.
  - 0x3 DISABLE: valid=0.
  - 0x4 LIGHT: payload[47:0] = light dir; index ignored.
  - 0x5 COMMIT.
  - Other opcodes, or index >= NUM_SPHERES for 0x1–0x3: word discarded, cmd_error set.
- Two banks; active_bank selects the rd_* outputs. Writes always target the shadow bank (!active_bank), one word per cycle, written the cycle after acceptance.
- FSM:
  - IDLE: accept words. COMMIT -> PENDING.
  - PENDING: wait frame_start. On frame_start: toggle active_bank -> COPY.
  - COPY: copy entry i of new active bank to shadow bank, i = 0..NUM_SPHERES-1, then light. Takes NUM_SPHERES+1 cycles. Then set recv_interrupt=1 -> IDLE.
- recv_interrupt clears on the cycle after any accepted recv_dv.
- Holding register (1 deep) for recv_dv arriving in PENDING or COPY:
  - If empty, the word is stored.
  - If full, the new word is dropped and overflow is set.
  - Drained in the first IDLE cycle, ahead of any new strobe that cycle; a same-cycle new strobe goes into the holding register.
- frame_start in IDLE or COPY: ignored.
- COMMIT arriving in PENDING/COPY is held like any other word and acts after return to IDLE.
- Reset (any state, including mid-COPY):
  - state=IDLE, active_bank=0.
  - All valid bits 0, all tables 0.
  - recv_interrupt=1 (ready for first scene).
  - cmd_error=0, overflow=0, holding register empty.
  - rd_* and light_dir read 0.
- Sticky flags clear only on reset.
- Latency:
  - Accepted word to shadow update: 1 cycle.
  - frame_start to new rd_* values: 1 cycle.
  - frame_start to recv_interrupt high: NUM_SPHERES+2 cycles.

Decomposition:
- Package scene_pkg:
  - opcode enum
  - sphere_t struct {pos, radius, color, valid}
  - COORD_W default
  - field bit-position localparams
- Sub-module scene_bank_ram: one 2-bank table with a shadow write port, an active read port and a copy read/write port, instantiated once for spheres. Light stays as two registers in the parent.

Test Plan:
- Reset, then POS idx2 {x=0x0010,y=0xFFF0,z=0x0100}, ATTR idx2 radius=0x0040 color=0xF00, COMMIT, frame_start -> 1 cycle later rd_idx=2 gives those values with rd_valid=1; recv_interrupt low after first word, high NUM_SPHERES+2 cycles after frame_start.
- Writes without COMMIT plus frame_start -> rd_* unchanged (0); active_bank unchanged.
- Opcode 0x9, and POS with idx=8 (NUM_SPHERES=8) -> cmd_error=1; table unchanged; a following valid word still applies.
- COMMIT, then two words sent before frame_start -> first held and applied after COPY (to new shadow), second dropped; overflow=1.
- After commit/copy, DISABLE idx2, COMMIT, frame_start -> rd_valid idx2=0 while idx2 position is retained (copy preserved it).
- Reset asserted mid-COPY -> all outputs return to reset values the same cycle; recv_interrupt=1.
